// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered read data and registered status flags.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow sticky until err_clr; otherwise they are one-cycle pulses.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic                    err_clr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic [CW-1:0]         count_nxt;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
  always_comb begin
    rd_acc    = rd_en & ~empty;
    wr_acc    = wr_en & (~full | rd_acc);
    ovf_evt   = wr_en & ~wr_acc;
    udf_evt   = rd_en & ~rd_acc;
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are computed from the next count so they line up with count in every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_data      <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
    end
  end

  // When full with a simultaneous read, rd_ptr == wr_ptr and the old word is read before being overwritten.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

`ifdef FIFO_STICKY_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_evt)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt;
      underflow <= udf_evt;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (DEPTH=16, DATA_WIDTH=8): per-cycle expectations are queued
// by the stimulus and popped by a monitor after each rising edge; hand checks cover key points.
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          err_clr;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  typedef struct packed {
    logic [4:0]    cnt;
    logic          f, e, af, ae, ov, ud;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] m_rd;
  logic          m_ov, m_ud;
  int            checks = 0;
  int            errors = 0;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .err_clr(err_clr), .rd_data(rd_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mdl.delete();
    m_rd = '0;
    m_ov = 1'b0;
    m_ud = 1'b0;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    logic rd_ok, wr_ok;
    int   n;
    exp_t e;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    n     = mdl.size();
    rd_ok = r && (n > 0);
    wr_ok = w && ((n < DP) || rd_ok);
    if (rd_ok) m_rd = mdl.pop_front();
    if (wr_ok) mdl.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
    if (w && !wr_ok) m_ov = 1'b1; else if (c) m_ov = 1'b0;
    if (r && !rd_ok) m_ud = 1'b1; else if (c) m_ud = 1'b0;
`else
    m_ov = w && !wr_ok;
    m_ud = r && !rd_ok;
`endif
    n    = mdl.size();
    e.cnt = 5'(n);
    e.f   = (n == DP);
    e.e   = (n == 0);
    e.af  = (n >= DP - 2);
    e.ae  = (n <= 2);
    e.ov  = m_ov;
    e.ud  = m_ud;
    e.rd  = m_rd;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares the DUT against the queued expectation once per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_count", 32'(count), 32'(e.cnt));
        chk("sb_full", 32'(full), 32'(e.f));
        chk("sb_empty", 32'(empty), 32'(e.e));
        chk("sb_almost_full", 32'(almost_full), 32'(e.af));
        chk("sb_almost_empty", 32'(almost_empty), 32'(e.ae));
        chk("sb_overflow", 32'(overflow), 32'(e.ov));
        chk("sb_underflow", 32'(underflow), 32'(e.ud));
        chk("sb_rd_data", 32'(rd_data), 32'(e.rd));
      end
    end
  end

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single word round trip
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    after_edge();
    chk("a5_count_after_wr", 32'(count), 32'd1);
    chk("a5_empty_after_wr", 32'(empty), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    after_edge();
    chk("a5_rd_data", 32'(rd_data), 32'hA5);
    chk("a5_count_after_rd", 32'(count), 32'd0);
    chk("a5_empty_after_rd", 32'(empty), 32'd1);

    // Fill to full, then one rejected write
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    after_edge();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_almost_full", 32'(almost_full), 32'd1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    after_edge();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read/write while full
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(16 + i), 1'b1, 1'b0);
    after_edge();
    chk("rw_full_rd_data", 32'(rd_data), 32'd19);
    chk("rw_full_count", 32'(count), 32'd16);
    chk("rw_full_overflow", 32'(overflow), 32'd0);

    // Drain across the wrap
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    after_edge();
    chk("drain_rd_data", 32'(rd_data), 32'd35);
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous read/write while empty
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    after_edge();
    chk("rw_empty_count", 32'(count), 32'd1);
    chk("rw_empty_underflow", 32'(underflow), 32'd1);
    chk("rw_empty_rd_hold", 32'(rd_data), 32'd35);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    after_edge();
    chk("rw_empty_next_rd", 32'(rd_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of traffic
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rel_empty", 32'(empty), 32'd1);
    chk("rel_count", 32'(count), 32'd0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    after_edge();
    chk("post_rst_first_rd", 32'(rd_data), 32'h77);

    // Underflow behaviour over idle cycles, then clear
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    after_edge();
    chk("udf_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    after_edge();
`ifdef FIFO_STICKY_ERR_EN
    chk("udf_held", 32'(underflow), 32'd1);
`else
    chk("udf_pulse_done", 32'(underflow), 32'd0);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    after_edge();
    chk("udf_cleared", 32'(underflow), 32'd0);

    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
